mem_access_master: RTL and testbench

- Initiator side of the byte-wide data-memory interface. The memory returns read data combinationally and writes on the clock edge.
- Accepts one multi-byte load/store request (1 to 4 bytes) from the datapath/controller and issues one memory access per byte to consecutive addresses.
- For loads, assembles the bytes into a little-endian word and returns it through a valid/ready response.
- Sits between the CPU controller and the data memory; used for 16/32-bit multi-precision operands.

---
 rtl/mem_access_pkg.sv | 15 +
 rtl/mem_access_master_if.sv | 35 +++
 rtl/mem_access_master.sv | 110 +++++++++++
 tb/tb_mem_access_master.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and default sizes for the byte-serial data-memory access master.
package mem_access_pkg;

  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_MAX_BYTES = 4;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned LEN_W         = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_master_if.sv
// Request/response and byte-memory bus of the access master.
// master: the access unit; slave: requester plus memory.
interface mem_access_master_if
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MAX_BYTES = DEF_MAX_BYTES
);

  logic                          req_valid;
  logic                          req_ready;
  logic                          req_write;
  logic [ADDR_W-1:0]             req_addr;
  logic [LEN_W-1:0]              req_len;
  logic [BYTE_W*MAX_BYTES-1:0]   req_wdata;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [BYTE_W*MAX_BYTES-1:0]   resp_rdata;
  logic                          resp_err;
  logic [ADDR_W-1:0]             mem_address;
  logic [BYTE_W-1:0]             mem_data;
  logic                          mem_store;
  logic [BYTE_W-1:0]             mem_out;

  modport master (
    input  req_valid, req_write, req_addr, req_len, req_wdata, resp_ready, mem_out,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_data, mem_store
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, req_wdata, resp_ready, mem_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_data, mem_store
  );

endinterface

// File: rtl/mem_access_master.sv
// Splits a 1..MAX_BYTES load/store into one byte access per cycle and packs load data little-endian.
// Optional MEM_ACCESS_MASTER_BOUNDS_CHECK_EN rejects requests running past the top address.
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MAX_BYTES = DEF_MAX_BYTES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_access_master_if.master  bus
);

  state_e                               state_q, state_d;
  logic                                 write_q;
  logic [LEN_W-1:0]                     len_q;
  logic [LEN_W-1:0]                     cnt_q;
  logic [MAX_BYTES-1:0][BYTE_W-1:0]     wdata_q;
  logic [MAX_BYTES-1:0][BYTE_W-1:0]     rdata_q;
  logic [ADDR_W-1:0]                    addr_q;
  logic [BYTE_W-1:0]                    data_q;
  logic                                 store_q;
  logic                                 err_q;
  logic                                 req_ready_q;
  logic                                 resp_valid_q;
  logic                                 oob_c;
  logic [LEN_W-1:0]                     cnt_nxt_c;

`ifdef MEM_ACCESS_MASTER_BOUNDS_CHECK_EN
  logic [ADDR_W:0] end_addr_c;
  assign end_addr_c = {1'b0, bus.req_addr} + (ADDR_W+1)'(bus.req_len);
  assign oob_c      = end_addr_c[ADDR_W];
`else
  assign oob_c = 1'b0;
`endif

  assign cnt_nxt_c = LEN_W'(cnt_q + 1'b1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = oob_c ? RESP : XFER;
      XFER:    if (cnt_q == len_q) state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: memory-side signals are preloaded one cycle ahead so they come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q      <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      store_q      <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      req_ready_q  <= (state_d == IDLE);
      resp_valid_q <= (state_d == RESP);
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            len_q   <= bus.req_len;
            cnt_q   <= '0;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            addr_q  <= bus.req_addr;
            data_q  <= bus.req_wdata[BYTE_W-1:0];
            store_q <= bus.req_write & ~oob_c;
            err_q   <= oob_c;
          end
        end
        XFER: begin
          if (!write_q) rdata_q[cnt_q] <= bus.mem_out;
          if (cnt_q == len_q) begin
            store_q <= 1'b0;
          end else begin
            cnt_q  <= cnt_nxt_c;
            addr_q <= ADDR_W'(addr_q + 1'b1);
            data_q <= wdata_q[cnt_nxt_c];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_store   = store_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: vector table, scoreboard and multi-cycle corner cases.
module tb_mem_access_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_master_if #(.ADDR_W(8), .MAX_BYTES(4)) bus ();

  mem_access_master #(.ADDR_W(8), .MAX_BYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte memory: combinational read, write on the clock edge
  logic [7:0] mem [256];
  assign bus.mem_out = mem[bus.mem_address];
  always @(posedge clk) if (bus.mem_store) mem[bus.mem_address] <= bus.mem_data;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic drive_req(input logic w, input logic [7:0] a, input logic [1:0] l, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_len   = l;
    bus.req_wdata = d;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e;
    exp_t        got;
    logic [31:0] w;
    w = v.wdata;
    wait_ready();
    drive_req(v.write, v.addr, v.len, v.wdata);
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check($sformatf("v%0d_req_ready_busy", idx), 32'(bus.req_ready), 32'd0);
    if (!v.exp_err) begin
      for (int k = 0; k <= int'(v.len); k++) begin
        check($sformatf("v%0d_addr%0d", idx, k), 32'(bus.mem_address), 32'(8'(v.addr + 8'(k))));
        check($sformatf("v%0d_store%0d", idx, k), 32'(bus.mem_store), 32'(v.write));
        check($sformatf("v%0d_early_valid%0d", idx, k), 32'(bus.resp_valid), 32'd0);
        if (v.write) check($sformatf("v%0d_data%0d", idx, k), 32'(bus.mem_data), 32'(w[8*k +: 8]));
        @(negedge clk);
      end
    end
    // Response must be present exactly now (len+2 cycles after acceptance, or 1 when rejected)
    check($sformatf("v%0d_resp_valid", idx), 32'(bus.resp_valid), 32'd1);
    check($sformatf("v%0d_resp_store", idx), 32'(bus.mem_store), 32'd0);
    bus.resp_ready = 1'b1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check($sformatf("v%0d_rdata", idx), bus.resp_rdata, got.rdata);
      check($sformatf("v%0d_err", idx), 32'(bus.resp_err), 32'(got.err));
    end else begin
      check($sformatf("v%0d_sb_empty", idx), 32'(sb.size()), 32'd1);
    end
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check($sformatf("v%0d_valid_drop", idx), 32'(bus.resp_valid), 32'd0);
    check($sformatf("v%0d_ready_back", idx), 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int          guard;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] <= ~8'(i);
    mem[100] <= 8'h01;
    mem[101] <= 8'h01;
    mem[102] <= 8'h04;
    mem[103] <= 8'h05;

    //            write  addr    len   wdata          exp_rdata      exp_err
    vecs[0] = '{1'b0, 8'd100, 2'd3, 32'h0,         32'h05040101, 1'b0};
    vecs[1] = '{1'b1, 8'd200, 2'd1, 32'h0000A5B6,  32'h0,        1'b0};
    vecs[2] = '{1'b0, 8'd103, 2'd0, 32'h0,         32'h00000005, 1'b0};
    vecs[3] = '{1'b0, 8'd200, 2'd2, 32'h0,         32'h0035A5B6, 1'b0};
`ifdef MEM_ACCESS_MASTER_BOUNDS_CHECK_EN
    vecs[4] = '{1'b1, 8'd254, 2'd3, 32'h44332211,  32'h0,        1'b1};
    vecs[5] = '{1'b0, 8'd254, 2'd3, 32'h0,         32'h0,        1'b1};
    vecs[6] = '{1'b0, 8'd255, 2'd0, 32'h0,         32'h00000000, 1'b0};
`else
    vecs[4] = '{1'b1, 8'd254, 2'd3, 32'h44332211,  32'h0,        1'b0};
    vecs[5] = '{1'b0, 8'd254, 2'd3, 32'h0,         32'h44332211, 1'b0};
    vecs[6] = '{1'b0, 8'd255, 2'd0, 32'h0,         32'h00000022, 1'b0};
`endif

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mem_store", 32'(bus.mem_store), 32'd0);
    check("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    check("mem200", 32'(mem[200]), 32'h B6);
    check("mem201", 32'(mem[201]), 32'h A5);
    check("mem202_untouched", 32'(mem[202]), 32'h35);
`ifdef MEM_ACCESS_MASTER_BOUNDS_CHECK_EN
    check("wrap_mem254", 32'(mem[254]), 32'h01);
    check("wrap_mem255", 32'(mem[255]), 32'h00);
    check("wrap_mem0", 32'(mem[0]), 32'hFF);
    check("wrap_mem1", 32'(mem[1]), 32'hFE);
`else
    check("wrap_mem254", 32'(mem[254]), 32'h11);
    check("wrap_mem255", 32'(mem[255]), 32'h22);
    check("wrap_mem0", 32'(mem[0]), 32'h33);
    check("wrap_mem1", 32'(mem[1]), 32'h44);
`endif

    // Backpressure: response held while a competing request is offered and ignored
    wait_ready();
    drive_req(1'b0, 8'd100, 2'd1, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    guard = 0;
    while (bus.resp_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
    held = bus.resp_rdata;
    check("bp_rdata", held, 32'h00000101);
    drive_req(1'b1, 8'd10, 2'd0, 32'h000000EE);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", c), 32'(bus.resp_valid), 32'd1);
      check($sformatf("bp_hold_rdata%0d", c), bus.resp_rdata, held);
      check($sformatf("bp_hold_ready%0d", c), 32'(bus.req_ready), 32'd0);
      check($sformatf("bp_hold_store%0d", c), 32'(bus.mem_store), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("bp_done_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    check("bp_ignored_mem10", 32'(mem[10]), 32'hF5);

    // Reset in the middle of a 4-byte store
    wait_ready();
    drive_req(1'b1, 8'd50, 2'd3, 32'hDDCCBBAA);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rm_addr0", 32'(bus.mem_address), 32'd50);
    @(negedge clk);
    check("rm_addr1", 32'(bus.mem_address), 32'd51);
    @(negedge clk);
    check("rm_store_before", 32'(bus.mem_store), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rm_store", 32'(bus.mem_store), 32'd0);
    check("rm_req_ready", 32'(bus.req_ready), 32'd1);
    check("rm_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rm_mem_address", 32'(bus.mem_address), 32'd0);
    check("rm_mem_data", 32'(bus.mem_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rm_no_resp%0d", c), 32'(bus.resp_valid), 32'd0);
    end
    check("rm_mem50", 32'(mem[50]), 32'hAA);
    check("rm_mem51", 32'(mem[51]), 32'hBB);
    check("rm_mem52", 32'(mem[52]), 32'hCB);
    check("rm_mem53", 32'(mem[53]), 32'hCA);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
